// File: rtl/fan_ctrl_pkg.sv
// rtl/fan_ctrl_pkg.sv - shared types and sizing helpers for the multi-channel fan controller
//
// Purpose: FSM state encoding for the time-multiplexed filter datapath,
// accumulator width helper and saturation limits derived from the ADC width.
// Ports: none (package).

package fan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_MAC4,
    ST_STORE
  } fsm_state_t;

  // Five products of (REG x ADC+1) bits plus sign headroom never overflow this.
  function automatic int acc_w(input int reg_w, input int adc_w);
    return reg_w + adc_w + 4;
  endfunction

  // Controller output is a signed (adc_w+1)-bit value: [-2^adc_w, 2^adc_w-1].
  function automatic int sat_hi(input int adc_w);
    return (1 << adc_w) - 1;
  endfunction

  function automatic int sat_lo(input int adc_w);
    return -(1 << adc_w);
  endfunction

endpackage

// File: rtl/fan_ctrl_multi_if.sv
// rtl/fan_ctrl_multi_if.sv - sample/coefficient/PWM bundle between host logic and fan_ctrl_multi
//
// Purpose: groups everything except clock, reset and clock enable.
// Signals:
//   sample_i              step strobe
//   adc_value_i/set_value_i  packed per-channel samples, channel n at [n*AW +: AW]
//   b2_i..a0_i            signed filter coefficients
//   pwm_period_i/pwm_min_i   PWM period (ticks) and minimum nonzero duty
//   pwm_o                 fan drive pins
//   pid_val_o             packed signed controller outputs, channel n at [n*(AW+1) +: AW+1]
//   busy_o/done_o/overrun_o  step status
// Modports: master drives the inputs, slave is the controller.

interface fan_ctrl_multi_if #(
  parameter int CHANNELS     = 4,
  parameter int ADC_BITWIDTH = 4,
  parameter int REG_BITWIDTH = 8
);
  localparam int AW = ADC_BITWIDTH;

  logic                           sample_i;
  logic [CHANNELS*AW-1:0]         adc_value_i;
  logic [CHANNELS*AW-1:0]         set_value_i;
  logic signed [REG_BITWIDTH-1:0] b2_i;
  logic signed [REG_BITWIDTH-1:0] b1_i;
  logic signed [REG_BITWIDTH-1:0] b0_i;
  logic signed [REG_BITWIDTH-1:0] a1_i;
  logic signed [REG_BITWIDTH-1:0] a0_i;
  logic [AW:0]                    pwm_period_i;
  logic [AW-1:0]                  pwm_min_i;
  logic [CHANNELS-1:0]            pwm_o;
  logic [CHANNELS*(AW+1)-1:0]     pid_val_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           overrun_o;

  modport master (
    output sample_i, adc_value_i, set_value_i,
    output b2_i, b1_i, b0_i, a1_i, a0_i,
    output pwm_period_i, pwm_min_i,
    input  pwm_o, pid_val_o, busy_o, done_o, overrun_o
  );

  modport slave (
    input  sample_i, adc_value_i, set_value_i,
    input  b2_i, b1_i, b0_i, a1_i, a0_i,
    input  pwm_period_i, pwm_min_i,
    output pwm_o, pid_val_o, busy_o, done_o, overrun_o
  );

endinterface

// File: rtl/fan_pwm_ch.sv
// rtl/fan_pwm_ch.sv - per-channel duty clamp, pending/active duty and PWM compare
//
// Purpose: turns one channel's saturated controller value into a PWM output
// against the shared period counter.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   store         controller value y is valid for this channel this cycle
//   y             signed controller value (AW+1 bits)
//   pwm_min       minimum nonzero duty
//   cnt           shared period counter
//   load          counter wraps to 0 (or PWM disabled): pending duty becomes active
//   en            PWM enabled (period nonzero)
//   pwm           fan drive output

module fan_pwm_ch #(
  parameter int AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               store,
  input  logic signed [AW:0] y,
  input  logic [AW-1:0]      pwm_min,
  input  logic [AW:0]        cnt,
  input  logic               load,
  input  logic               en,
  output logic               pwm
);

  logic [AW:0] mag;
  logic [AW:0] duty_new;
  logic [AW:0] pending_q;
  logic [AW:0] active_q;

  // Negation of the most negative value (-2^AW) yields 2^AW, which fits unsigned.
  assign mag = $unsigned(-y);

  // Only negative outputs drive the fan; small nonzero duties are raised to the minimum.
  always_comb begin
    duty_new = '0;
    if (y[AW]) begin
      duty_new = (mag < {1'b0, pwm_min}) ? {1'b0, pwm_min} : mag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      if (store) begin
        pending_q <= duty_new;
      end
      // The compare value changes only at period start so no period is cut short.
      if (load) begin
        active_q <= pending_q;
      end
    end
  end

  assign pwm = en & (cnt < active_q);

endmodule

// File: rtl/fan_ctrl_multi.sv
// rtl/fan_ctrl_multi.sv - time-multiplexed IIR fan controller serving CHANNELS fans
//
// Purpose: one shared multiply-accumulate walks all channels per sample strobe,
// keeping per-channel error/output history, and drives one PWM pin per fan.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   clk_en_i  PWM counter advance enable
//   bus       fan_ctrl_multi_if slave: samples, coefficients, PWM setup, outputs, status

module fan_ctrl_multi
  import fan_ctrl_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int ADC_BITWIDTH  = 4,
  parameter int REG_BITWIDTH  = 8,
  parameter int FRAC_BITWIDTH = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  fan_ctrl_multi_if.slave bus
);

  localparam int AW    = ADC_BITWIDTH;
  localparam int RW    = REG_BITWIDTH;
  localparam int EW    = AW + 1;
  localparam int PW    = RW + EW;
  localparam int ACC_W = acc_w(RW, AW);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(AW));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(AW));

  // ---------------------------------------------------------------- FSM
  fsm_state_t      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            done_q, done_d;
  logic            store;
  logic            last_ch;
  logic            busy;

  assign busy    = (state_q != ST_IDLE);
  assign last_ch = (ch_q == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    store   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_i) begin
          state_d = ST_LOAD;
          ch_d    = '0;
        end
      end
      ST_LOAD: state_d = ST_MAC0;
      ST_MAC0: state_d = ST_MAC1;
      ST_MAC1: state_d = ST_MAC2;
      ST_MAC2: state_d = ST_MAC3;
      ST_MAC3: state_d = ST_MAC4;
      ST_MAC4: state_d = ST_STORE;
      ST_STORE: begin
        store = 1'b1;
        if (last_ch) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  logic [AW-1:0]           set_ch, adc_ch;
  logic signed [EW-1:0]    e_new, e_cur_q;
  logic signed [EW-1:0]    e1_q  [CHANNELS];
  logic signed [EW-1:0]    e2_q  [CHANNELS];
  logic signed [EW-1:0]    y1_q  [CHANNELS];
  logic signed [EW-1:0]    y2_q  [CHANNELS];
  logic signed [EW-1:0]    pid_q [CHANNELS];
  logic signed [RW-1:0]    mul_coef;
  logic signed [EW-1:0]    mul_op;
  logic                    mul_sub;
  logic                    mac_en;
  logic signed [PW-1:0]    coef_x, op_x, prod;
  logic signed [ACC_W-1:0] prod_x, acc_q, acc_d, acc_shr;
  logic signed [EW-1:0]    y_sat;

  assign set_ch = bus.set_value_i[ch_q*AW +: AW];
  assign adc_ch = bus.adc_value_i[ch_q*AW +: AW];
  assign e_new  = $signed({1'b0, set_ch}) - $signed({1'b0, adc_ch});

  // One coefficient/history pair per MAC cycle; feedback terms are subtracted.
  always_comb begin
    mul_coef = '0;
    mul_op   = '0;
    mul_sub  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      ST_MAC0: begin mul_coef = bus.b2_i; mul_op = e_cur_q;    mac_en = 1'b1; end
      ST_MAC1: begin mul_coef = bus.b1_i; mul_op = e1_q[ch_q]; mac_en = 1'b1; end
      ST_MAC2: begin mul_coef = bus.b0_i; mul_op = e2_q[ch_q]; mac_en = 1'b1; end
      ST_MAC3: begin mul_coef = bus.a1_i; mul_op = y1_q[ch_q]; mac_en = 1'b1; mul_sub = 1'b1; end
      ST_MAC4: begin mul_coef = bus.a0_i; mul_op = y2_q[ch_q]; mac_en = 1'b1; mul_sub = 1'b1; end
      default: ;
    endcase
  end

  // Operands are sign-extended to the full product width so the multiply is exact.
  assign coef_x = {{(PW-RW){mul_coef[RW-1]}}, mul_coef};
  assign op_x   = {{(PW-EW){mul_op[EW-1]}}, mul_op};
  assign prod   = coef_x * op_x;
  assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_d  = mul_sub ? (acc_q - prod_x) : (acc_q + prod_x);

  // Arithmetic shift floors toward minus infinity before clamping.
  assign acc_shr = acc_q >>> FRAC_BITWIDTH;

  always_comb begin
    if (acc_shr > SAT_HI) begin
      y_sat = SAT_HI[EW-1:0];
    end else if (acc_shr < SAT_LO) begin
      y_sat = SAT_LO[EW-1:0];
    end else begin
      y_sat = acc_shr[EW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_cur_q <= '0;
      acc_q   <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        e1_q[n]  <= '0;
        e2_q[n]  <= '0;
        y1_q[n]  <= '0;
        y2_q[n]  <= '0;
        pid_q[n] <= '0;
      end
    end else begin
      if (state_q == ST_LOAD) begin
        e_cur_q <= e_new;
        acc_q   <= '0;
      end
      if (mac_en) begin
        acc_q <= acc_d;
      end
      // History advances only once this channel's new output is final.
      if (store) begin
        e2_q[ch_q]  <= e1_q[ch_q];
        e1_q[ch_q]  <= e_cur_q;
        y2_q[ch_q]  <= y1_q[ch_q];
        y1_q[ch_q]  <= y_sat;
        pid_q[ch_q] <= y_sat;
      end
    end
  end

  logic [CHANNELS*EW-1:0] pid_flat;

  always_comb begin
    pid_flat = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      pid_flat[n*EW +: EW] = pid_q[n];
    end
  end

  // --------------------------------------------------------------- PWM
  logic [EW-1:0]       cnt_q;
  logic                period_zero;
  logic                cnt_end;
  logic                wrap;
  logic [CHANNELS-1:0] pwm;

  assign period_zero = (bus.pwm_period_i == '0);
  // ">=" lets a shortened period take effect at once instead of counting past it.
  assign cnt_end     = (cnt_q >= (bus.pwm_period_i - EW'(1)));
  assign wrap        = clk_en_i & ~period_zero & cnt_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (period_zero || wrap) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      cnt_q <= cnt_q + EW'(1);
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    fan_pwm_ch #(
      .AW(AW)
    ) u_pwm (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .store   (store && (ch_q == CH_W'(n))),
      .y       (y_sat),
      .pwm_min (bus.pwm_min_i),
      .cnt     (cnt_q),
      .load    (wrap | period_zero),
      .en      (~period_zero),
      .pwm     (pwm[n])
    );
  end

  // ----------------------------------------------------------- outputs
  assign bus.pwm_o     = pwm;
  assign bus.pid_val_o = pid_flat;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done_q;
  assign bus.overrun_o = bus.sample_i & busy;

endmodule
